// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one multi-cycle SRAM between fetch reads and loader writes.
// Reads park in RD_WAIT for MEM_LAT cycles; a taken branch discards the word that comes back.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | memory free; at most one read or one write issued this cycle
// S_RD_WAIT | read outstanding; counter runs down to the data-return cycle
module imem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              branch_taken,
   output logic              if_freeze,
   output logic [DATA_W-1:0] if_inst,
   output logic              if_valid,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_RD_WAIT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              r_kill;
   logic              w_kill_nxt;
   logic              r_last_ld;
   logic              w_last_ld_nxt;
   logic [DATA_W-1:0] r_inst;
   logic [DATA_W-1:0] w_inst_nxt;

   logic w_idle;
   logic w_sel_rd;
   logic w_sel_wr;
   logic w_issue_rd;
   logic w_issue_wr;
   logic w_ret;
   logic w_deliver;

   // Round-robin: on contention the requester that did not go last wins.
   assign w_idle     = (r_state == S_IDLE);
   assign w_sel_rd   = if_req & (~ld_req | r_last_ld);
   assign w_sel_wr   = ld_req & (~if_req | ~r_last_ld);
   // Issues are gated by rst so the memory port is quiet the moment reset asserts.
   assign w_issue_rd = rst & w_idle & w_sel_rd & ~branch_taken;
   assign w_issue_wr = rst & w_idle & w_sel_wr;
   assign w_ret      = (r_state == S_RD_WAIT) & (r_cnt <= 4'd1);
   assign w_deliver  = w_ret & ~r_kill & ~branch_taken;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_kill    <= 1'b0;
         r_last_ld <= 1'b0;
         r_inst    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_kill    <= w_kill_nxt;
         r_last_ld <= w_last_ld_nxt;
         r_inst    <= w_inst_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_kill_nxt    = r_kill;
      w_last_ld_nxt = r_last_ld;
      w_inst_nxt    = r_inst;
      case (r_state)
         S_IDLE: begin
            if (w_issue_rd) begin
               w_state_nxt   = S_RD_WAIT;
               w_cnt_nxt     = LAT_CNT;
               w_kill_nxt    = 1'b0;
               w_last_ld_nxt = 1'b0;
            end else if (w_issue_wr) begin
               w_last_ld_nxt = 1'b1;
            end
         end
         S_RD_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (branch_taken) begin
               w_kill_nxt = 1'b1;
            end
            if (w_deliver) begin
               w_inst_nxt = mem_rdata;
            end
            if (w_ret) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_kill_nxt  = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      mem_en    = w_issue_rd | w_issue_wr;
      mem_we    = w_issue_wr;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_issue_rd) begin
         mem_addr = if_addr;
      end else if (w_issue_wr) begin
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end
      ld_gnt    = w_issue_wr;
      if_valid  = w_deliver;
      // The returning word is forwarded in its own cycle so if_valid and if_inst line up.
      if_inst   = w_deliver ? mem_rdata : r_inst;
      if_freeze = rst & if_req & ~w_deliver & ~branch_taken;
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: three latency builds share random stimulus, each with its own
// memory responder and a cycle-numbered reference model of the arbitration rules.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        branch_taken = 1'b0;
   logic        ld_req = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [31:0] ld_wdata = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_lat
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

      logic        d_freeze, d_valid, d_gnt, d_en, d_we;
      logic [31:0] d_inst, d_addr, d_wdata;
      logic [31:0] d_rdata = '0;

      imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
         .clk(clk), .rst(rst),
         .if_req(if_req), .if_addr(if_addr), .branch_taken(branch_taken),
         .if_freeze(d_freeze), .if_inst(d_inst), .if_valid(d_valid),
         .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(d_gnt),
         .mem_en(d_en), .mem_we(d_we), .mem_addr(d_addr), .mem_wdata(d_wdata),
         .mem_rdata(d_rdata)
      );

      // Memory responder: data appears only on the cycle LAT after the read strobe.
      logic [31:0] dev_mem [logic [31:0]];
      int          pend_cyc = -1;
      logic [31:0] pend_data = '0;

      always @(posedge clk) begin
         #1;
         d_rdata = (cyc == pend_cyc) ? pend_data : $urandom;
      end

      always @(negedge clk) begin
         if (d_en && !d_we) begin
            pend_cyc  = cyc + LAT;
            pend_data = dev_mem.exists(d_addr) ? dev_mem[d_addr] : (d_addr ^ 32'hA5A5_0000);
         end
         if (d_en && d_we) dev_mem[d_addr] = d_wdata;
      end

      // Reference model: state is "busy until cycle m_ret", not a counter.
      logic [31:0] ref_mem [logic [31:0]];
      bit          m_busy = 0, m_kill = 0, m_last_ld = 0;
      int          m_ret = 0;
      logic [31:0] m_inst = '0, m_data = '0;
      bit          rd, wr, e_en, e_we, e_gnt, e_val, e_frz;
      logic [31:0] e_addr, e_wd, e_inst;

      always @(negedge clk) begin
         e_en = 0; e_we = 0; e_gnt = 0; e_val = 0; e_addr = '0; e_wd = '0;
         if (!rst) begin
            m_busy = 0; m_kill = 0; m_last_ld = 0; m_inst = '0;
         end else if (!m_busy) begin
            rd = if_req && (!ld_req || m_last_ld) && !branch_taken;
            wr = ld_req && (!if_req || !m_last_ld);
            e_en  = rd || wr;
            e_we  = wr;
            e_gnt = wr;
            e_addr = rd ? if_addr : (wr ? ld_addr : 32'h0);
            e_wd   = wr ? ld_wdata : 32'h0;
            if (rd) begin
               m_busy = 1; m_ret = cyc + LAT; m_kill = 0; m_last_ld = 0;
               m_data = ref_mem.exists(if_addr) ? ref_mem[if_addr] : (if_addr ^ 32'hA5A5_0000);
            end
            if (wr) begin
               m_last_ld = 1;
               ref_mem[ld_addr] = ld_wdata;
            end
         end else begin
            e_val = (cyc == m_ret) && !m_kill && !branch_taken;
            if (e_val) m_inst = m_data;
            if (branch_taken) m_kill = 1;
            if (cyc == m_ret) begin
               m_busy = 0; m_kill = 0;
            end
         end
         e_inst = m_inst;
         e_frz  = rst && if_req && !e_val && !branch_taken;
         chk($sformatf("L%0d mem_en", LAT),    32'(d_en),    32'(e_en));
         chk($sformatf("L%0d mem_we", LAT),    32'(d_we),    32'(e_we));
         chk($sformatf("L%0d mem_addr", LAT),  d_addr,       e_addr);
         chk($sformatf("L%0d mem_wdata", LAT), d_wdata,      e_wd);
         chk($sformatf("L%0d ld_gnt", LAT),    32'(d_gnt),   32'(e_gnt));
         chk($sformatf("L%0d if_valid", LAT),  32'(d_valid), 32'(e_val));
         chk($sformatf("L%0d if_inst", LAT),   d_inst,       e_inst);
         chk($sformatf("L%0d if_freeze", LAT), 32'(d_freeze), 32'(e_frz));
      end

      // Outputs must clear as soon as reset asserts, before any clock edge.
      always @(negedge rst) begin
         #1;
         chk($sformatf("L%0d rst mem_en", LAT),    32'(d_en),     32'h0);
         chk($sformatf("L%0d rst ld_gnt", LAT),    32'(d_gnt),    32'h0);
         chk($sformatf("L%0d rst if_valid", LAT),  32'(d_valid),  32'h0);
         chk($sformatf("L%0d rst if_freeze", LAT), 32'(d_freeze), 32'h0);
         chk($sformatf("L%0d rst if_inst", LAT),   d_inst,        32'h0);
         chk($sformatf("L%0d rst mem_addr", LAT),  d_addr,        32'h0);
      end
   end

   task automatic step(input bit ir, input logic [31:0] ia, input bit br,
                       input bit lr, input logic [31:0] la, input logic [31:0] lw);
      @(posedge clk);
      #1;
      if_req = ir; if_addr = ia; branch_taken = br;
      ld_req = lr; ld_addr = la; ld_wdata = lw;
   endtask

   int pct_if [4] = '{90, 50, 100, 70};
   int pct_ld [4] = '{30, 80, 100, 50};
   int pct_br [4] = '{10, 5, 0, 25};
   bit gnt0;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      repeat (6) step(1, 32'h10, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h0, 32'h1111_0000);
      step(0, 0, 0, 1, 32'h4, 32'h2222_0004);
      step(0, 0, 0, 1, 32'h8, 32'h3333_0008);
      for (int i = 0; i < 48; i++) step(1, 32'(i % 3) << 2, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) step(1, 32'h30, 0, 1, 32'h40 + 32'(i), $urandom);
      repeat (17) step(0, 0, 0, 0, 0, 0);

      step(1, 32'h20, 0, 0, 0, 0);
      step(1, 32'h20, 1, 0, 0, 0);
      repeat (20) step(1, 32'h24, 0, 0, 0, 0);

      // Reset dropped mid-read, between clock edges.
      repeat (3) step(1, 32'h2C, 0, 0, 0, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (20) step(1, 32'h14, 0, 0, 0, 0);

      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 700; i++) begin
            if (ld_req && !gnt0)
               step($urandom_range(0, 99) < pct_if[p], 32'($urandom_range(0, 15)) << 2,
                    $urandom_range(0, 99) < pct_br[p], 1, ld_addr, ld_wdata);
            else
               step($urandom_range(0, 99) < pct_if[p], 32'($urandom_range(0, 15)) << 2,
                    $urandom_range(0, 99) < pct_br[p], $urandom_range(0, 99) < pct_ld[p],
                    32'($urandom_range(0, 15)) << 2, $urandom);
            @(negedge clk);
            gnt0 = g_lat[0].d_gnt;
         end
      end

      repeat (18) step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
